// File: rtl/cache_miss_controller.sv
// Read sequencer between a CPU requester, a direct-mapped block cache and main memory.
// Hits return the cached word; misses fetch the 4-word block, fill the cache, then respond.
module cache_miss_controller #(
  parameter int WORD     = 32,
  parameter int ADDRESSL = 12,
  parameter int TAG      = 3,
  parameter int BLOCKL   = 4,
  parameter int CNTW     = 16,
  localparam int AW      = ADDRESSL + TAG
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cpu_req,
  input  logic [AW-1:0]          cpu_addr,
  output logic                   cpu_ready,
  output logic [WORD-1:0]        cpu_data,
  output logic                   busy,
  output logic [AW-1:0]          cache_addr,
  output logic                   cRead,
  input  logic                   hit,
  input  logic [WORD-1:0]        cache_data,
  output logic                   cWrite,
  output logic [AW-1:0]          adr0,
  output logic [AW-1:0]          adr1,
  output logic [AW-1:0]          adr2,
  output logic [AW-1:0]          adr3,
  output logic [BLOCKL*WORD-1:0] block_data,
  output logic                   mem_read,
  output logic [AW-1:0]          mem_addr,
  input  logic                   mem_ready,
  input  logic [BLOCKL*WORD-1:0] mem_data,
  output logic [CNTW-1:0]        hit_count,
  output logic [CNTW-1:0]        miss_count
);

  typedef enum logic [2:0] {IDLE, LOOKUP, MEM_WAIT, FILL, RESP} stateT;

  stateT                   state;
  logic [AW-1:0]           addrQ;
  logic [BLOCKL*WORD-1:0]  blockQ;
  logic [WORD-1:0]         memWords [BLOCKL];

  genvar gi;
  generate
    for (gi = 0; gi < BLOCKL; gi++) begin : gMemWords
      assign memWords[gi] = mem_data[gi*WORD +: WORD];
    end
  endgenerate

  assign cache_addr = addrQ;
  assign adr0       = {addrQ[AW-1:2], 2'd0};
  assign adr1       = {addrQ[AW-1:2], 2'd1};
  assign adr2       = {addrQ[AW-1:2], 2'd2};
  assign adr3       = {addrQ[AW-1:2], 2'd3};
  assign mem_addr   = {addrQ[AW-1:2], 2'd0};
  assign block_data = blockQ;

  // Strobes are registered alongside the next state, so each one is a pure
  // function of the state being entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      addrQ      <= '0;
      blockQ     <= '0;
      cpu_data   <= '0;
      hit_count  <= '0;
      miss_count <= '0;
      cpu_ready  <= 1'b0;
      cRead      <= 1'b0;
      cWrite     <= 1'b0;
      mem_read   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      cpu_ready <= 1'b0;
      cRead     <= 1'b0;
      cWrite    <= 1'b0;
      mem_read  <= 1'b0;
      busy      <= 1'b1;
      case (state)
        IDLE: begin
          if (cpu_req) begin
            addrQ <= cpu_addr;
            state <= LOOKUP;
            cRead <= 1'b1;
          end else begin
            busy <= 1'b0;
          end
        end
        LOOKUP: begin
          if (hit) begin
            cpu_data  <= cache_data;
            if (hit_count != '1) hit_count <= hit_count + 1'b1;
            state     <= RESP;
            cpu_ready <= 1'b1;
          end else begin
            if (miss_count != '1) miss_count <= miss_count + 1'b1;
            state    <= MEM_WAIT;
            mem_read <= 1'b1;
          end
        end
        MEM_WAIT: begin
          if (mem_ready) begin
            blockQ   <= mem_data;
            cpu_data <= memWords[addrQ[1:0]];
            state    <= FILL;
            cWrite   <= 1'b1;
          end else begin
            mem_read <= 1'b1;
          end
        end
        FILL: begin
          state     <= RESP;
          cpu_ready <= 1'b1;
        end
        RESP: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
